// File: rtl/multicycle_exec.sv
// Multi-cycle execute unit: register file, synchronous single-port RAM, ALU and
// control FSM. Define EXEC_MULDIV_EN to build MUL/DIV; otherwise opcodes 3/4 are reserved.
module multicycle_exec #(
  parameter int DATA_W  = 4,
  parameter int REG_AW  = 4,
  parameter int MEM_AW  = 4,
  parameter int INSTR_W = 4 + REG_AW + MEM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  imm,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic               res_valid,
  output logic               zero,
  output logic               div0,
  output logic               illegal
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   ra_q, ra_d;
  logic [MEM_AW-1:0]   ma_q, ma_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic                alu_div0_q, alu_div0_d;
  logic                alu_ill_q, alu_ill_d;
  logic                wr_reg_q, wr_reg_d;
  logic                wr_mem_q, wr_mem_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                res_valid_q, res_valid_d;
  logic                zero_q, zero_d;
  logic                div0_q, div0_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic [DATA_W-1:0]   mem_q  [NMEM];
  logic [DATA_W-1:0]   mem_rd_q;
  logic [DATA_W-1:0]   opa, opb;

`ifdef EXEC_MULDIV_EN
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W-1:0] quot;
`endif

  assign instr_ready = (state_q == IDLE) && rst;
  assign result      = result_q;
  assign res_valid   = res_valid_q;
  assign zero        = zero_q;
  assign div0        = div0_q;
  assign illegal     = illegal_q;

  assign opa = regs_q[ra_q];
  assign opb = mem_rd_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    ma_d        = ma_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    alu_div0_d  = alu_div0_q;
    alu_ill_d   = alu_ill_q;
    wr_reg_d    = wr_reg_q;
    wr_mem_d    = wr_mem_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    zero_d      = zero_q;
    div0_d      = div0_q;
    illegal_d   = illegal_q;
    regs_d      = regs_q;
`ifdef EXEC_MULDIV_EN
    quot        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          op_d    = instr[INSTR_W-1 -: 4];
          ra_d    = instr[MEM_AW +: REG_AW];
          ma_d    = instr[MEM_AW-1:0];
          imm_d   = imm;
          state_d = RD;
        end
      end
      RD: state_d = EX;
      EX: begin
        alu_d      = '0;
        alu_div0_d = 1'b0;
        alu_ill_d  = 1'b0;
        wr_reg_d   = 1'b0;
        wr_mem_d   = 1'b0;
        case (op_q)
          4'h0: alu_d = '0;
          4'h1: begin alu_d = opa + opb;    wr_reg_d = 1'b1; end
          4'h2: begin alu_d = opa - opb;    wr_reg_d = 1'b1; end
`ifdef EXEC_MULDIV_EN
          4'h3: begin alu_d = opa * opb;    wr_reg_d = 1'b1; end
          4'h4: begin
            wr_reg_d = 1'b1;
            if (opb == '0) begin
              alu_d      = '1;
              alu_div0_d = 1'b1;
            end else if (opa == MIN_VAL && opb == '1) begin
              alu_d = MIN_VAL;
            end else begin
              quot  = $signed(opa) / $signed(opb);
              alu_d = quot;
            end
          end
`endif
          4'h5: begin alu_d = opa & opb;    wr_reg_d = 1'b1; end
          4'h6: begin alu_d = opa | opb;    wr_reg_d = 1'b1; end
          4'h7: begin alu_d = ~(opa | opb); wr_reg_d = 1'b1; end
          4'h8: begin alu_d = opa ^ opb;    wr_reg_d = 1'b1; end
          4'h9: begin alu_d = {opa[0], opa[DATA_W-1:1]};        wr_reg_d = 1'b1; end
          4'hA: begin alu_d = {opa[DATA_W-2:0], opa[DATA_W-1]}; wr_reg_d = 1'b1; end
          4'hB: begin alu_d = opb;          wr_reg_d = 1'b1; end
          4'hC: begin alu_d = opa;          wr_mem_d = 1'b1; end
          4'hD: begin alu_d = imm_q;        wr_reg_d = 1'b1; end
          default: alu_ill_d = 1'b1;
        endcase
        state_d = WB;
      end
      WB: begin
        result_d    = alu_q;
        zero_d      = (alu_q == '0);
        div0_d      = alu_div0_q;
        illegal_d   = alu_ill_q;
        res_valid_d = 1'b1;
        if (wr_reg_q) regs_d[ra_q] = alu_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      ra_q        <= '0;
      ma_q        <= '0;
      imm_q       <= '0;
      alu_q       <= '0;
      alu_div0_q  <= 1'b0;
      alu_ill_q   <= 1'b0;
      wr_reg_q    <= 1'b0;
      wr_mem_q    <= 1'b0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      ma_q        <= ma_d;
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      alu_div0_q  <= alu_div0_d;
      alu_ill_q   <= alu_ill_d;
      wr_reg_q    <= wr_reg_d;
      wr_mem_q    <= wr_mem_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      zero_q      <= zero_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
      regs_q      <= regs_d;
    end
  end

  // RAM keeps its contents through reset; a reset in WB suppresses the store.
  always_ff @(posedge clk) begin
    if (state_q == RD) mem_rd_q <= mem_q[ma_q];
    if (rst && state_q == WB && wr_mem_q) mem_q[ma_q] <= alu_q;
  end

endmodule

// File: tb/tb_multicycle_exec.sv
// Self-checking bench for multicycle_exec: directed scenarios plus random
// instructions compared against an arithmetic reference model.
module tb_multicycle_exec;
  localparam int DW = 4;
  localparam int RW = 4;
  localparam int MW = 4;
  localparam int IW = 4 + RW + MW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [DW-1:0] imm = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [DW-1:0] result;
  logic          res_valid, zero, div0, illegal;

  multicycle_exec #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imm(imm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .result(result), .res_valid(res_valid),
    .zero(zero), .div0(div0), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int m_reg [16];
  int m_mem [16];

  task automatic model(input int op, input int ra, input int ma, input int imm_v,
                       output int res, output int z, output int d0, output int ill);
    int a, b, sa, sb;
    a = m_reg[ra];
    b = m_mem[ma];
    res = 0; d0 = 0; ill = 0;
    case (op)
      0:  res = 0;
      1:  res = (a + b) & 15;
      2:  res = (a - b) & 15;
`ifdef EXEC_MULDIV_EN
      3:  res = (a * b) & 15;
      4: begin
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (b == 0) begin res = 15; d0 = 1; end
        else if (sa == -8 && sb == -1) res = 8;
        else res = (sa / sb) & 15;
      end
`endif
      5:  res = a & b;
      6:  res = a | b;
      7:  res = (~(a | b)) & 15;
      8:  res = a ^ b;
      9:  res = ((a >> 1) | (a << 3)) & 15;
      10: res = ((a << 1) | (a >> 3)) & 15;
      11: res = b;
      12: begin res = a; m_mem[ma] = a; end
      13: res = imm_v & 15;
      default: ill = 1;
    endcase
    if (!ill && ((op >= 1 && op <= 11) || op == 13)) m_reg[ra] = res;
    z = (res == 0) ? 1 : 0;
  endtask

  task automatic do_instr(input int op, input int ra, input int ma, input int imm_v);
    int er, ez, ed, ei, waited;
    logic [31:0] w;
    waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      check("ready_timeout", {31'd0, instr_ready}, 1);
      return;
    end
    w = {20'd0, op[3:0], ra[3:0], ma[3:0]};
    instr = w[IW-1:0];
    w = imm_v;
    imm = w[DW-1:0];
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = IW'($urandom);
    imm   = DW'($urandom);
    model(op, ra, ma, imm_v, er, ez, ed, ei);
    @(posedge clk); #1;
    check("busy_ready", {31'd0, instr_ready}, 0);
    @(posedge clk); #1;
    check("early_valid", {31'd0, res_valid}, 0);
    @(posedge clk); #1;
    check("res_valid", {31'd0, res_valid}, 1);
    check("result", {28'd0, result}, er);
    check("zero", {31'd0, zero}, ez);
    check("div0", {31'd0, div0}, ed);
    check("illegal", {31'd0, illegal}, ei);
    check("ready_back", {31'd0, instr_ready}, 1);
  endtask

  initial begin
    int acc [$];
    int gap_low, k, er, ez, ed, ei;
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin m_reg[i] = 0; m_mem[i] = 0; end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, instr_ready}, 0);
    check("rst_valid", {31'd0, res_valid}, 0);
    check("rst_result", {28'd0, result}, 0);
    check("rst_flags", {29'd0, zero, div0, illegal}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, instr_ready}, 1);

    // LDI and zero flag, one-cycle strobe with held result
    do_instr(13, 1, 0, 5);
    check("ldi5", {28'd0, result}, 5);
    @(posedge clk); #1;
    check("strobe_width", {31'd0, res_valid}, 0);
    check("result_hold", {28'd0, result}, 5);
    do_instr(13, 2, 0, 0);
    check("ldi0_zero", {31'd0, zero}, 1);

    // STR/ADD/LDR read-after-write
    do_instr(13, 1, 0, 3);
    do_instr(12, 1, 4, 0);
    do_instr(13, 2, 0, 6);
    do_instr(1, 2, 4, 0);
    check("add9", {28'd0, result}, 9);
    do_instr(11, 0, 4, 0);
    check("ldr3", {28'd0, result}, 3);

    // rotates, register file checked through STR
    do_instr(13, 3, 0, 3);
    do_instr(9, 3, 4, 0);
    check("ror", {28'd0, result}, 9);
    do_instr(12, 3, 5, 0);
    check("ror_reg", {28'd0, result}, 9);
    do_instr(13, 4, 0, 8);
    do_instr(10, 4, 4, 0);
    check("rol", {28'd0, result}, 1);
    do_instr(12, 4, 5, 0);
    check("rol_reg", {28'd0, result}, 1);

    // MUL/DIV, or their reserved behaviour
    do_instr(13, 5, 0, 2);
    do_instr(12, 5, 6, 0);
    do_instr(13, 5, 0, 0);
    do_instr(12, 5, 7, 0);
    do_instr(13, 6, 0, 9);
`ifdef EXEC_MULDIV_EN
    do_instr(4, 6, 6, 0);
    check("div_neg", {28'd0, result}, 13);
    do_instr(4, 6, 7, 0);
    check("div0_res", {28'd0, result}, 15);
    check("div0_flag", {31'd0, div0}, 1);
`else
    do_instr(3, 6, 6, 0);
    check("mul_illegal", {31'd0, illegal}, 1);
    check("mul_res", {28'd0, result}, 0);
    do_instr(4, 6, 7, 0);
    check("div_no_div0", {31'd0, div0}, 0);
    do_instr(12, 6, 8, 0);
    check("reg_untouched", {28'd0, result}, 9);
`endif
    do_instr(0, 0, 0, 0);
    check("nop_clear", {29'd0, zero, div0, illegal}, 4);
    do_instr(14, 1, 4, 0);
    check("op_e_illegal", {31'd0, illegal}, 1);

    // back-to-back acceptance with instr_valid held
    k = 0;
    gap_low = 0;
    @(negedge clk);
    w = {20'd0, 4'hD, 4'd8, 4'd0};
    instr = w[IW-1:0];
    imm = 4'd1;
    instr_valid = 1'b1;
    for (int t = 0; t < 40 && k < 3; t++) begin
      @(negedge clk);
      if (instr_ready) begin
        acc.push_back(cyc);
        model(13, 8 + k, 0, k + 1, er, ez, ed, ei);
        k++;
        @(posedge clk); #1;
        w = {20'd0, 4'hD, 4'(8 + k), 4'd0};
        instr = w[IW-1:0];
        imm = DW'(k + 1);
        if (k == 3) instr_valid = 1'b0;
      end else if (k > 0 && k < 3) begin
        gap_low++;
      end
    end
    instr_valid = 1'b0;
    check("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      check("b2b_gap1", acc[1] - acc[0], 4);
      check("b2b_gap2", acc[2] - acc[1], 4);
    end
    check("b2b_ready_low", gap_low, 6);
    repeat (4) @(posedge clk);
    do_instr(12, 10, 9, 0);
    check("b2b_reg", {28'd0, result}, 3);

    // reset during EX of ADD
    @(negedge clk);
    w = {20'd0, 4'h1, 4'd2, 4'd4};
    instr = w[IW-1:0];
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", {31'd0, res_valid}, 0);
    check("abort_ready", {31'd0, instr_ready}, 0);
    @(posedge clk); #1;
    check("abort_result", {28'd0, result}, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    @(posedge clk); #1;
    check("abort_ready_back", {31'd0, instr_ready}, 1);
    check("abort_no_valid", {31'd0, res_valid}, 0);
    do_instr(12, 2, 9, 0);
    check("abort_reg", {28'd0, result}, 0);
    do_instr(11, 1, 4, 0);
    check("ram_kept", {28'd0, result}, 3);

    // randomized instructions
    for (int i = 0; i < 16; i++) begin
      do_instr(13, 0, 0, $urandom_range(0, 15));
      do_instr(12, 0, i, 0);
    end
    for (int i = 0; i < 150; i++)
      do_instr($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
